// File: rtl/conv_weight_loader.sv
// conv_weight_loader
//   Receives framed weight-update packets on a byte-wide valid/ready stream.
//   It buffers each packet and verifies its checksum. It then writes the full
//   FILTER_SIZE x FILTER_SIZE kernel into the weight memory of the selected
//   conv calc engine, one entry per cycle.
//   Frame: SYNC_BYTE, index, FILTER_SIZE^2 signed weights, checksum.
//   The checksum is the 8-bit sum of the index byte and all weight bytes.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_data/s_valid    input byte stream; s_ready is the loader's back-pressure
//   calc_weight_en    one-hot engine write enable (only during a commit)
//   calc_weight_addr  weight index shared by all engines
//   calc_weight_in    signed weight value shared by all engines
//   load_done         one-cycle pulse after a completed commit
//   load_err          one-cycle pulse on a rejected frame; err_code gives the
//                     reason (01 checksum, 10 bad index, 11 both)
//   filter_loaded     sticky per-engine "complete kernel received" flags
module conv_weight_loader #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FILTER_SIZE = 7,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned ADDR_BITS   = 6,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [NUM_FILTERS-1:0]      calc_weight_en,
  output logic [ADDR_BITS-1:0]        calc_weight_addr,
  output logic signed [DATA_BITS-1:0] calc_weight_in,
  output logic                        load_done,
  output logic                        load_err,
  output logic [1:0]                  err_code,
  output logic [NUM_FILTERS-1:0]      filter_loaded
);

  localparam int unsigned          NUM_W  = FILTER_SIZE * FILTER_SIZE;
  localparam logic [ADDR_BITS-1:0] LAST_K = ADDR_BITS'(NUM_W - 1);
  localparam logic [7:0]           NF_B   = 8'(NUM_FILTERS);

  typedef enum logic [2:0] {
    S_IDLE, S_INDEX, S_PAYLOAD, S_CHECK, S_COMMIT, S_DONE
  } state_t;

  state_t                      state_q;
  logic                        s_ready_q;
  logic [NUM_FILTERS-1:0]      en_q;
  logic [ADDR_BITS-1:0]        addr_q;
  logic signed [DATA_BITS-1:0] wdata_q;
  logic                        done_q;
  logic                        err_q;
  logic [1:0]                  code_q;
  logic [NUM_FILTERS-1:0]      loaded_q;
  logic [7:0]                  idx_q;
  logic                        bad_idx_q;
  logic [7:0]                  csum_q;
  logic [ADDR_BITS-1:0]        cnt_q;

  // Payload buffer: pure data, never reset; each accepted frame rewrites it all.
  logic signed [DATA_BITS-1:0] wbuf_q [2**ADDR_BITS];

  logic                        xfer;
  logic [ADDR_BITS-1:0]        addr_nxt;

  assign xfer     = s_valid && s_ready_q;
  assign addr_nxt = addr_q + 1'b1;

  function automatic logic [NUM_FILTERS-1:0] onehot(input logic [7:0] idx);
    logic [NUM_FILTERS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_FILTERS; i++) oh[i] = (idx == 8'(i));
    return oh;
  endfunction

  always_ff @(posedge clk) begin
    if (xfer && state_q == S_PAYLOAD) wbuf_q[cnt_q] <= DATA_BITS'(s_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      s_ready_q <= 1'b1;
      en_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
      loaded_q  <= '0;
      idx_q     <= '0;
      bad_idx_q <= 1'b0;
      csum_q    <= '0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      code_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          // Anything other than the sync marker is dropped while hunting.
          if (xfer && s_data == SYNC_BYTE) state_q <= S_INDEX;
        end
        S_INDEX: begin
          if (xfer) begin
            idx_q     <= s_data;
            csum_q    <= s_data;
            bad_idx_q <= (s_data >= NF_B);
            cnt_q     <= '0;
            state_q   <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            csum_q <= csum_q + s_data;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LAST_K) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (s_data == csum_q && !bad_idx_q) begin
              // First commit write is presented in the cycle right after
              // the checksum byte, so en covers exactly NUM_W cycles.
              state_q   <= S_COMMIT;
              s_ready_q <= 1'b0;
              en_q      <= onehot(idx_q);
              addr_q    <= '0;
              wdata_q   <= wbuf_q[0];
            end else begin
              state_q <= S_IDLE;
              err_q   <= 1'b1;
              code_q  <= {bad_idx_q, s_data != csum_q};
            end
          end
        end
        S_COMMIT: begin
          if (addr_q == LAST_K) begin
            en_q     <= '0;
            done_q   <= 1'b1;
            loaded_q <= loaded_q | onehot(idx_q);
            state_q  <= S_DONE;
          end else begin
            addr_q  <= addr_nxt;
            wdata_q <= wbuf_q[addr_nxt];
          end
        end
        S_DONE: begin
          s_ready_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready          = s_ready_q;
  assign calc_weight_en   = en_q;
  assign calc_weight_addr = addr_q;
  assign calc_weight_in   = wdata_q;
  assign load_done        = done_q;
  assign load_err         = err_q;
  assign err_code         = code_q;
  assign filter_loaded    = loaded_q;

endmodule

// File: tb/tb_conv_weight_loader.sv
// Self-checking bench for conv_weight_loader: table of directed frames,
// randomized frames against a frame-level model, and a reset-during-commit
// sequence.
module tb_conv_weight_loader;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [3:0]        calc_weight_en;
  logic [5:0]        calc_weight_addr;
  logic signed [7:0] calc_weight_in;
  logic              load_done;
  logic              load_err;
  logic [1:0]        err_code;
  logic [3:0]        filter_loaded;

  always #5 clk = ~clk;

  conv_weight_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .calc_weight_en(calc_weight_en), .calc_weight_addr(calc_weight_addr),
    .calc_weight_in(calc_weight_in), .load_done(load_done), .load_err(load_err),
    .err_code(err_code), .filter_loaded(filter_loaded)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor log, sampled on the falling edge.
  typedef struct { logic [3:0] en; logic [5:0] addr; int d; int cyc; } wr_t;
  wr_t        wr_q[$];
  int         done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0, rdy_low = 0;
  logic [1:0] err_seen = 2'b00;
  bit         multihot = 1'b0;

  always @(negedge clk) begin
    if (calc_weight_en != 4'b0000) begin
      wr_q.push_back('{calc_weight_en, calc_weight_addr, int'(calc_weight_in), cyc});
      if ($countones(calc_weight_en) != 1) multihot = 1'b1;
    end
    if (load_done) begin done_cnt++; done_cyc = cyc; end
    if (load_err) begin err_cnt++; err_cyc = cyc; err_seen = err_code; end
    if (!s_ready) rdy_low++;
  end

  logic [7:0] fw [49];
  logic [3:0] fl_model;

  typedef struct {
    logic [7:0] idx; int pat; logic [7:0] wval; logic [7:0] csum;
    int lead; int gapm; logic [1:0] exp_code; logic [3:0] exp_fl;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Frame-level model: checksum and reject reason from the frame rules.
  function automatic logic [7:0] model_sum(input logic [7:0] idx);
    int s;
    s = int'(idx);
    for (int k = 0; k < 49; k++) s += int'(fw[k]);
    return 8'(s % 256);
  endfunction

  function automatic logic [1:0] model_code(input logic [7:0] idx, input logic [7:0] csum);
    logic [1:0] c;
    c[1] = (idx >= 8'd4);
    c[0] = (model_sum(idx) != csum);
    return c;
  endfunction

  function automatic logic [3:0] oh4(input logic [7:0] i);
    return (i < 8'd4) ? (4'b0001 << i[1:0]) : 4'b0000;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gapm, output int t_acc);
    int n;
    int g;
    n = 0;
    while (!s_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!s_ready) chk(1'b0, "ready_timeout", 0, 1);
    s_data  = b;
    s_valid = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc;
    if (gapm != 0) begin
      g = (gapm == 1) ? 1 : int'($urandom_range(0, 3));
      s_valid = 1'b0;
      repeat (g) begin s_data = 8'($urandom); @(posedge clk); #1; end
    end
  endtask

  task automatic run_frame(input logic [7:0] idx, input logic [7:0] csum, input int lead,
                           input int gapm, input logic [1:0] exp_code,
                           input logic [3:0] exp_fl, input string nm);
    int wb, db, eb, rb, t, tmp, nw, bad_k, act_d, exp_d;
    bit okf;
    wb = wr_q.size(); db = done_cnt; eb = err_cnt; rb = rdy_low;
    for (int i = 0; i < lead; i++) send_byte((i % 2 == 1) ? 8'h3C : 8'h00, 0, tmp);
    send_byte(8'hA5, 0, tmp);
    send_byte(idx, 0, tmp);
    for (int k = 0; k < 49; k++) send_byte(fw[k], gapm, tmp);
    send_byte(csum, 0, t);
    s_valid = 1'b0;
    t = t - 1;  // cycle in which the checksum byte was accepted
    repeat (56) @(posedge clk);
    @(negedge clk);
    okf = (exp_code == 2'b00);
    nw  = wr_q.size() - wb;
    chk(nw == (okf ? 49 : 0), {nm, " write_count"}, nw, okf ? 49 : 0);
    if (okf) begin
      bad_k = -1; act_d = 0; exp_d = 0;
      for (int k = 0; k < nw && k < 49; k++) begin
        if (bad_k < 0 && (wr_q[wb+k].en != oh4(idx) || int'(wr_q[wb+k].addr) != k ||
            wr_q[wb+k].d != int'($signed(fw[k])) || wr_q[wb+k].cyc != t + 1 + k)) begin
          bad_k = k; act_d = wr_q[wb+k].d; exp_d = int'($signed(fw[k]));
        end
      end
      chk(bad_k == -1, {nm, " write_entry(data)"}, act_d, exp_d);
      chk(done_cyc == t + 50, {nm, " done_cycle"}, done_cyc - t, 50);
    end else begin
      chk(err_cyc == t + 1, {nm, " err_cycle"}, err_cyc - t, 1);
      chk(err_seen == exp_code, {nm, " err_code"}, int'(err_seen), int'(exp_code));
    end
    chk(done_cnt - db == (okf ? 1 : 0), {nm, " done_count"}, done_cnt - db, okf ? 1 : 0);
    chk(err_cnt - eb == (okf ? 0 : 1), {nm, " err_count"}, err_cnt - eb, okf ? 0 : 1);
    chk(filter_loaded == exp_fl, {nm, " filter_loaded"}, int'(filter_loaded), int'(exp_fl));
    chk(rdy_low - rb == (okf ? 50 : 0), {nm, " ready_low_cycles"}, rdy_low - rb, okf ? 50 : 0);
    chk(multihot == 1'b0, {nm, " en_onehot"}, int'(multihot), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         tmp, wb, db;
    bit         found;
    logic [7:0] ridx, rc;
    logic [1:0] rcode;

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; fl_model = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(s_ready == 1'b1, "reset s_ready", int'(s_ready), 1);
    chk(calc_weight_en == 4'b0000, "reset en", int'(calc_weight_en), 0);
    chk(calc_weight_addr == 6'd0, "reset addr", int'(calc_weight_addr), 0);
    chk(calc_weight_in == 8'sd0, "reset wdata", int'(calc_weight_in), 0);
    chk(load_done == 1'b0 && load_err == 1'b0, "reset pulses", int'({load_done, load_err}), 0);
    chk(err_code == 2'b00, "reset err_code", int'(err_code), 0);
    chk(filter_loaded == 4'b0000, "reset filter_loaded", int'(filter_loaded), 0);

    // idx, pattern(0 ramp k+1 / 1 const), wval, csum, lead garbage, gap mode, code, filter_loaded
    vecs[0] = '{8'h02, 0, 8'h00, 8'hCB, 0, 0, 2'b00, 4'b0100};
    vecs[1] = '{8'h02, 0, 8'h00, 8'hCC, 0, 0, 2'b01, 4'b0100};
    vecs[2] = '{8'h05, 1, 8'hFF, 8'hD4, 0, 0, 2'b10, 4'b0100};
    vecs[3] = '{8'h00, 1, 8'h80, 8'h80, 2, 0, 2'b00, 4'b0101};
    vecs[4] = '{8'h07, 1, 8'h00, 8'h08, 0, 0, 2'b11, 4'b0101};
    vecs[5] = '{8'h01, 1, 8'hA5, 8'h96, 0, 0, 2'b00, 4'b0111};
    vecs[6] = '{8'h03, 0, 8'h00, 8'hCC, 0, 1, 2'b00, 4'b1111};

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 49; k++) fw[k] = (vecs[v].pat == 0) ? 8'(k + 1) : vecs[v].wval;
      run_frame(vecs[v].idx, vecs[v].csum, vecs[v].lead, vecs[v].gapm,
                vecs[v].exp_code, vecs[v].exp_fl, $sformatf("vec%0d", v));
    end
    fl_model = 4'b1111;

    for (int r = 0; r < 8; r++) begin
      ridx = 8'($urandom_range(0, 5));
      for (int k = 0; k < 49; k++) fw[k] = 8'($urandom);
      rc = model_sum(ridx);
      if ($urandom_range(0, 3) == 0) rc = rc + 8'($urandom_range(1, 255));
      rcode = model_code(ridx, rc);
      if (rcode == 2'b00) fl_model = fl_model | oh4(ridx);
      run_frame(ridx, rc, int'($urandom_range(0, 2)), 2, rcode, fl_model,
                $sformatf("rand%0d", r));
    end

    // Reset in the middle of a commit (while entry 20 is being written).
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 49; k++) fw[k] = 8'(k + 1);
    send_byte(8'hA5, 0, tmp);
    send_byte(8'h01, 0, tmp);
    for (int k = 0; k < 49; k++) send_byte(fw[k], 0, tmp);
    send_byte(model_sum(8'h01), 0, tmp);
    s_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clk);
      if (calc_weight_en != 4'b0000 && calc_weight_addr == 6'd20) found = 1'b1;
    end
    chk(found, "rstc reach_k20", int'(found), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk(calc_weight_en == 4'b0000, "rstc en", int'(calc_weight_en), 0);
    chk(s_ready == 1'b1, "rstc s_ready", int'(s_ready), 1);
    chk(filter_loaded == 4'b0000, "rstc filter_loaded", int'(filter_loaded), 0);
    wb = wr_q.size(); db = done_cnt;
    repeat (60) @(negedge clk);
    chk(done_cnt == db, "rstc no_done", done_cnt - db, 0);
    chk(wr_q.size() == wb, "rstc no_writes", wr_q.size() - wb, 0);

    for (int k = 0; k < 49; k++) fw[k] = 8'(k + 1);
    run_frame(8'h02, model_sum(8'h02), 0, 0, 2'b00, 4'b0100, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_weight_loader.md
Name: conv_weight_loader

Overview:
- Receives framed weight-update packets over a byte-wide valid/ready stream.
- Buffers and checksum-verifies each packet, then writes a full FILTER_SIZE×FILTER_SIZE kernel into one selected conv calc engine's writable weight memory, one entry per cycle.
- Sits between the host/config interface and the bank of conv layer-1 calc engines.
- Is the writer side of their calc_weight_en / calc_weight_addr / calc_weight_in port.

Parameters:
- DATA_BITS, 8, weight width in bits.
- FILTER_SIZE, 7, kernel side length; a packet carries FILTER_SIZE*FILTER_SIZE (49) weights.
- NUM_FILTERS, 4, number of calc engines served, one enable bit each.
- ADDR_BITS, 6, weight address width; must satisfy 2^ADDR_BITS >= FILTER_SIZE*FILTER_SIZE.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a byte; a byte transfers when s_valid && s_ready.
- calc_weight_en  out  NUM_FILTERS  one-hot write enable, bit i drives engine i.
- calc_weight_addr  out  ADDR_BITS  weight index, shared by all engines.
- calc_weight_in  out  DATA_BITS (signed)  weight value, shared by all engines.
- load_done  out  1  one-cycle pulse when a commit completes.
- load_err  out  1  one-cycle pulse when a frame is rejected.
- err_code  out  2  reason for the reject, valid while load_err=1: 01 checksum, 10 bad index, 11 both.
- filter_loaded  out  NUM_FILTERS  sticky bit i set after engine i receives a complete commit.

Behaviour:
- Reset, effective next edge:
  - State returns to IDLE.
  - s_ready=1.
  - calc_weight_en=0, calc_weight_addr=0, calc_weight_in=0.
  - load_done=0, load_err=0, err_code=0, filter_loaded=0.
  - Payload counter and checksum accumulator cleared.
  - Reset during COMMIT aborts the commit: en is 0 from the next cycle. The partly written engine is not flagged.
- All outputs are registered.
- Frame format: SYNC_BYTE, index byte, 49 weight bytes (two's complement), checksum byte.
  - Checksum = unsigned 8-bit sum mod 256 of the index byte and all 49 weight bytes.
- States:
  - IDLE: s_ready=1. SYNC_BYTE moves to INDEX; any other byte is silently dropped.
  - INDEX: s_ready=1. Latch index and seed checksum with it. Set bad_idx if index >= NUM_FILTERS. Move to PAYLOAD.
  - PAYLOAD: s_ready=1. Store byte k into local buffer[k] and add it to the checksum, for k=0..48. After byte 48 move to CHECK.
  - CHECK: s_ready=1. On checksum byte:
    - Match and !bad_idx: move to COMMIT.
    - Otherwise: load_err=1 and err_code set on the next cycle, then return to IDLE. No weight writes occur.
  - COMMIT: s_ready=0. Runs 49 consecutive cycles, k=0..48. In each cycle calc_weight_en=onehot(index), calc_weight_addr=k, calc_weight_in=buffer[k]. After k=48 move to DONE.
  - DONE: s_ready=0 for one cycle. calc_weight_en=0, load_done=1, filter_loaded[index] set. Next state IDLE.
- Timing, with checksum accepted at cycle T:
  - calc_weight_en high in cycles T+1..T+49.
  - load_done at T+50.
  - s_ready high again at T+51.
  - Error path: load_err at T+1; s_ready stays 1 throughout.
- s_valid low mid-frame: the FSM waits indefinitely and the counter holds. There is no timeout.
- A SYNC_BYTE value inside the payload or checksum is treated as data, not a resync.
- calc_weight_en is never multi-hot and never asserted outside COMMIT.
- Back-to-back frames: a new SYNC_BYTE is accepted in the first IDLE cycle after DONE or after a reject.
- The buffer is not cleared between frames; every entry is rewritten by each accepted frame.

Test Plan:
1. Reset, then frame A5, 02, weights 0x01..0x31, checksum (2+1225) mod 256 = 0xCB -> calc_weight_en=4'b0100 for 49 cycles, addr 0..48, data 0x01..0x31; load_done one cycle later; filter_loaded=4'b0100; s_ready low exactly 50 cycles.
2. Same frame with checksum 0xCC -> load_err=1, err_code=01; calc_weight_en never asserts; filter_loaded unchanged.
3. Index 0x05, all weights 0xFF, correct checksum (0x05+49*0xFF) mod 256 = 0xD4 -> load_err, err_code=10; no writes.
4. Leading garbage 00, 3C, then a valid frame for index 0 with weights 0x80 (-128) -> garbage dropped; 49 writes of 0x80 to engine 0; calc_weight_in reads as -128.
5. s_valid toggled 1-0-1 on every payload byte, with a random-gap frame for index 3 -> same writes as a gap-free frame; no bytes lost or duplicated.
6. Assert rst at commit cycle k=20 -> en=0 from the next cycle; filter_loaded=0; no load_done; s_ready=1; a following valid frame loads normally.
